// File: rtl/float_adder_arbiter.sv
// Round-robin front end that time-shares one floating-point adder among NUM_REQ
// requesters, with a watchdog that substitutes NAN_VALUE when the adder stalls.
module float_adder_arbiter #(
   parameter int                    NUM_REQ        = 4,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 64,
   parameter logic [DATA_WIDTH-1:0] NAN_VALUE      = 32'h7FC00000
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   output logic                          add_start,
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   input  logic                          add_done,
   input  logic [DATA_WIDTH-1:0]         add_result,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_next;
   logic [ID_W-1:0]       ptr, ptr_next, grant_next, winner;
   logic                  win_found;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [DATA_WIDTH-1:0] add_a_next, add_b_next, rsp_data_next;
   logic                  rsp_err_next;

   // Scan from the highest offset down so the requester closest to ptr is the last, winning write.
   always_comb begin
      int idx;
      idx       = 0;
      winner    = '0;
      win_found = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[idx]) begin
            winner    = ID_W'(idx);
            win_found = 1'b1;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      ptr_next      = ptr;
      grant_next    = grant_id;
      cnt_next      = cnt;
      add_a_next    = add_a;
      add_b_next    = add_b;
      rsp_data_next = rsp_data;
      rsp_err_next  = rsp_err;
      req_ready     = '0;
      rsp_valid     = '0;
      case (state)
         IDLE: begin
            if (win_found) begin
               req_ready[winner] = 1'b1;
               add_a_next        = req_a[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
               add_b_next        = req_b[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
               grant_next        = winner;
               state_next        = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A done on the expiry cycle still returns the real sum.
            if (add_done) begin
               rsp_data_next = add_result;
               rsp_err_next  = 1'b0;
               state_next    = RESP;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_next = NAN_VALUE;
               rsp_err_next  = 1'b1;
               state_next    = RESP;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_ready[grant_id]) begin
               ptr_next   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_id <= '0;
         cnt      <= '0;
         add_a    <= '0;
         add_b    <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         grant_id <= grant_next;
         cnt      <= cnt_next;
         add_a    <= add_a_next;
         add_b    <= add_b_next;
         rsp_data <= rsp_data_next;
         rsp_err  <= rsp_err_next;
      end
   end

   assign add_start = (state == ISSUE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Directed bench for float_adder_arbiter: a small adder model with fixed latency plus
// injected add_done pulses for the timeout, late-done and collision cases.
module tb_float_adder_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            ACLK = 1'b0;
   logic            ARESET = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_a = '0;
   logic [N*DW-1:0] req_b = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '1;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;
   logic            add_start;
   logic [DW-1:0]   add_a, add_b;
   logic            add_done;
   logic [DW-1:0]   add_result;
   logic            busy;
   logic [1:0]      grant_id;

   logic            model_en = 1'b1;
   logic            model_done = 1'b0;
   logic [DW-1:0]   model_result = '0;
   int              lat_cnt = 0;
   logic            inj_done = 1'b0;
   logic [DW-1:0]   inj_result = '0;

   int n_checks = 0;
   int n_fail   = 0;

   float_adder_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .NAN_VALUE(32'h7FC00000)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .add_start(add_start), .add_a(add_a), .add_b(add_b),
      .add_done(add_done), .add_result(add_result),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 ACLK = ~ACLK;

   assign add_done   = model_done | inj_done;
   assign add_result = inj_done ? inj_result : model_result;

   // Hand-computed IEEE-754 sums for the operand pairs used below.
   function automatic logic [DW-1:0] fp_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
      case ({a, b})
         64'h3F800000_40000000: fp_sum = 32'h40400000;  // 1 + 2 = 3
         64'h40000000_40000000: fp_sum = 32'h40800000;  // 2 + 2 = 4
         64'h3F800000_3F800000: fp_sum = 32'h40000000;  // 1 + 1 = 2
         64'h40800000_40800000: fp_sum = 32'h41000000;  // 4 + 4 = 8
         default:               fp_sum = 32'hDEADBEEF;
      endcase
   endfunction

   // Adder with latency 3: done is high in the third cycle after the add_start cycle.
   always @(negedge ACLK) begin
      model_done = 1'b0;
      if (lat_cnt > 0) begin
         lat_cnt = lat_cnt - 1;
         if (lat_cnt == 0) begin
            model_done   = 1'b1;
            model_result = fp_sum(add_a, add_b);
         end
      end
      if (add_start && model_en) lat_cnt = 3;
   end

   task automatic tick();
      @(negedge ACLK);
   endtask

   task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[idx*DW +: DW] = a;
      req_b[idx*DW +: DW] = b;
   endtask

   task automatic do_reset();
      ARESET    = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      tick();
      tick();
      ARESET = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      tick();
      tick();
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      n_checks++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL reset_add_start: got %b want 0", add_start); end
      n_checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin n_fail++; $display("FAIL reset_add_ab: got %h/%h want 0/0", add_a, add_b); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
      ARESET = 1'b0;
   endtask

   task automatic test_single();
      int cycles, starts;
      set_req(0, 32'h3F800000, 32'h40000000);
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_checks++; if (add_start !== 1'b1) begin n_fail++; $display("FAIL single_add_start: got %b want 1", add_start); end
      n_checks++; if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin n_fail++; $display("FAIL single_add_ab: got %h/%h want 3f800000/40000000", add_a, add_b); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_req_ready_issue: got %b want 0000", req_ready); end
      cycles = 1;
      starts = 0;
      while (rsp_valid == 4'b0000 && cycles < 40) begin
         tick();
         cycles++;
         if (add_start) starts++;
      end
      n_checks++; if (cycles !== 5) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 5", cycles); end
      n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL single_start_pulse: got %0d extra start cycles want 0", starts); end
      n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h40400000) begin n_fail++; $display("FAIL single_rsp_data: got %h want 40400000", rsp_data); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
      tick();
      n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got valid %b busy %b want 0000/0", rsp_valid, busy); end
   endtask

   task automatic test_contention();
      logic [DW-1:0] exp_sum [4];
      int cycles, id;
      exp_sum = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h41000000};
      do_reset();
      set_req(0, 32'h3F800000, 32'h40000000);
      set_req(1, 32'h40000000, 32'h40000000);
      set_req(2, 32'h3F800000, 32'h3F800000);
      set_req(3, 32'h40800000, 32'h40800000);
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         id = k % 4;
         cycles = 0;
         while (rsp_valid == 4'b0000 && cycles < 40) begin
            tick();
            cycles++;
         end
         n_checks++; if (rsp_valid !== (4'b0001 << id)) begin n_fail++; $display("FAIL contention_valid op%0d: got %b want one-hot %0d", k, rsp_valid, id); end
         n_checks++; if (grant_id !== 2'(id)) begin n_fail++; $display("FAIL contention_grant op%0d: got %0d want %0d", k, grant_id, id); end
         n_checks++; if (rsp_data !== exp_sum[id]) begin n_fail++; $display("FAIL contention_data op%0d: got %h want %h", k, rsp_data, exp_sum[id]); end
         n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL contention_ready op%0d: got %b want 0000", k, req_ready); end
         if (k == 5) req_valid = 4'b0000;
         tick();
      end
      tick();
   endtask

   task automatic test_timeout();
      int cycles;
      model_en  = 1'b0;
      rsp_ready = 4'b0000;
      set_req(3, 32'h3F800000, 32'h3F800000);
      req_valid = 4'b1000;
      #1;
      n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL timeout_req_ready: got %b want 1000", req_ready); end
      tick();
      req_valid = 4'b0000;
      cycles = 1;
      while (rsp_valid == 4'b0000 && cycles < 40) begin
         tick();
         cycles++;
      end
      n_checks++; if (cycles !== 10) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want 10", cycles); end
      n_checks++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL timeout_rsp_valid: got %b want 1000", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h7FC00000) begin n_fail++; $display("FAIL timeout_rsp_data: got %h want 7fc00000", rsp_data); end
      n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_err: got %b want 1", rsp_err); end
      inj_result = 32'h12345678;
      inj_done   = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      n_checks++; if (rsp_data !== 32'h7FC00000 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL late_done: got %h err %b want 7fc00000 err 1", rsp_data, rsp_err); end
      n_checks++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL late_done_valid: got %b want 1000", rsp_valid); end
      rsp_ready = 4'b1111;
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_exit: got busy %b want 0", busy); end
      model_en = 1'b1;
   endtask

   task automatic test_backpressure();
      int cycles;
      rsp_ready = 4'b1101;
      set_req(1, 32'h40000000, 32'h40000000);
      set_req(0, 32'h3F800000, 32'h40000000);
      req_valid = 4'b0010;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_req_ready: got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0001;
      cycles = 1;
      while (rsp_valid == 4'b0000 && cycles < 40) begin
         tick();
         cycles++;
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_valid cyc%0d: got %b want 0010", i, rsp_valid); end
         n_checks++; if (rsp_data !== 32'h40800000) begin n_fail++; $display("FAIL bp_data cyc%0d: got %h want 40800000", i, rsp_data); end
         n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err cyc%0d: got %b want 0", i, rsp_err); end
         n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready cyc%0d: got %b want 0000", i, req_ready); end
         tick();
      end
      rsp_ready = 4'b1111;
      tick();
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_ready: got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_checks++; if (grant_id !== 2'd0 || add_start !== 1'b1) begin n_fail++; $display("FAIL bp_next_grant: got id %0d start %b want 0/1", grant_id, add_start); end
      cycles = 1;
      while (rsp_valid == 4'b0000 && cycles < 40) begin
         tick();
         cycles++;
      end
      n_checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h40400000) begin n_fail++; $display("FAIL bp_next_rsp: got %b/%h want 0001/40400000", rsp_valid, rsp_data); end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int cycles;
      set_req(2, 32'h3F800000, 32'h3F800000);
      set_req(3, 32'h40800000, 32'h40800000);
      req_valid = 4'b0100;
      #1;
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_wait_req_ready: got %b want 0100", req_ready); end
      tick();
      req_valid = 4'b0000;
      tick();
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      n_checks++; if (busy !== 1'b0 || add_start !== 1'b0) begin n_fail++; $display("FAIL rst_wait_state: got busy %b start %b want 0/0", busy, add_start); end
      n_checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_wait_handshakes: got %b/%b want 0000/0000", rsp_valid, req_ready); end
      n_checks++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_wait_rsp: got %h err %b want 0/0", rsp_data, rsp_err); end
      n_checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin n_fail++; $display("FAIL rst_wait_add_ab: got %h/%h want 0/0", add_a, add_b); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_wait_grant: got %0d want 0", grant_id); end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stale_done cyc%0d: got valid %b busy %b want 0000/0", i, rsp_valid, busy); end
      end
      req_valid = 4'b1001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_wait_pointer: got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      cycles = 1;
      while (rsp_valid == 4'b0000 && cycles < 40) begin
         tick();
         cycles++;
      end
      n_checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h40400000) begin n_fail++; $display("FAIL rst_wait_after: got %b/%h want 0001/40400000", rsp_valid, rsp_data); end
      tick();
   endtask

   task automatic test_collision();
      model_en = 1'b0;
      set_req(1, 32'h40000000, 32'h40000000);
      req_valid = 4'b0010;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL coll_req_ready: got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0000;
      repeat (8) tick();
      n_checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL coll_early_expiry: got valid %b busy %b want 0000/1", rsp_valid, busy); end
      inj_result = 32'h41200000;
      inj_done   = 1'b1;
      tick();
      inj_done = 1'b0;
      n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL coll_valid: got %b want 0010", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h41200000) begin n_fail++; $display("FAIL coll_data: got %h want 41200000", rsp_data); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL coll_err: got %b want 0", rsp_err); end
      tick();
      model_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_backpressure();
      test_reset_mid_wait();
      test_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/float_adder_arbiter.md
Name: float_adder_arbiter

Overview:
- Round-robin scheduler that shares one float_adder core among NUM_REQ requesters.
- Accepts one operand pair at a time, issues a single-cycle start pulse to the adder and waits for its done.
- Returns the result to the granted requester, with a watchdog on adder latency.
- Sits between the AXI4-Lite register front-ends (or other masters) and the single shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the watchdog fires (≥2).
- NAN_VALUE, 32'h7FC00000, result returned on timeout.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- rsp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DATA_WIDTH  result, shared bus, valid with rsp_valid.
- rsp_err  out  1  result is a timeout substitute.
- add_start  out  1  one-cycle start pulse to adder.
- add_a  out  DATA_WIDTH  adder operand A.
- add_b  out  DATA_WIDTH  adder operand B.
- add_done  in  1  adder result valid (one cycle).
- add_result  in  DATA_WIDTH  adder sum.
- busy  out  1  state != IDLE.
- grant_id  out  clog2(NUM_REQ)  index of current/last grantee.

Behaviour:
- Reset (ARESET=1 at a rising edge): state=IDLE, priority pointer=0, grant_id=0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, add_start, add_a, add_b, busy.
  - Timeout counter=0.
  - Reset mid-operation aborts the op silently: no response, and a later add_done is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner g = first i with req_valid[i]=1, scanning pointer, pointer+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge: latch req_a[g]/req_b[g] into add_a/add_b, set grant_id=g, go ISSUE.
  - No valid request: stay in IDLE.
  - add_done in IDLE is ignored.
- ISSUE:
  - add_start=1 for exactly this cycle; add_a/add_b are stable from here until RESP exits.
  - Clear timeout counter, go WAIT.
  - add_done during ISSUE is ignored (adder latency ≥1).
- WAIT:
  - add_done=1: latch add_result into rsp_data, rsp_err=0, go RESP.
  - Otherwise increment counter. If counter==TIMEOUT_CYCLES-1 with no done: rsp_data=NAN_VALUE, rsp_err=1, go RESP.
  - If add_done coincides with the expiry cycle, done wins (rsp_err=0).
- RESP:
  - rsp_valid[grant_id]=1; rsp_data/rsp_err held stable until rsp_ready[grant_id]=1.
  - On handshake: pointer=(grant_id+1) mod NUM_REQ, rsp_valid→0, go IDLE.
  - rsp_ready of other indices is ignored.
  - add_done arriving in RESP (late, after timeout) is ignored and does not overwrite rsp_data.
- req_ready is never asserted outside IDLE. Requesters hold req_valid and operands until accepted; dropping them early is not checked.
- Throughput: one operation per (adder latency + 3) cycles minimum with rsp_ready tied high. Adder latency counts from the add_start cycle to the add_done cycle.
- Fairness: a continuously valid requester is granted within NUM_REQ operations.
- A requester may present a new request while its own response is pending; it is considered only after returning to IDLE.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Single request, adder model latency 3: req 0 presents A=0x3F800000, B=0x40000000.
  - req_ready[0] pulses once; add_start pulses one cycle later.
  - rsp_valid[0] with rsp_data=0x40400000, rsp_err=0.
  - Total accept-to-rsp_valid = 5 cycles.
- Contention: all 4 requesters valid continuously.
  - Grant order 0,1,2,3,0,1; each rsp_valid appears only on the granted index.
  - Results match per-requester operands (e.g. 1.0+1.0=0x40000000 for requester 2).
- Timeout: TIMEOUT_CYCLES=8, adder model never asserts done.
  - rsp_data=0x7FC00000 and rsp_err=1 after 8 WAIT cycles.
  - A late add_done injected during RESP leaves rsp_data unchanged.
- Backpressure: rsp_ready[1] held low 10 cycles.
  - rsp_valid[1], rsp_data and rsp_err stay stable.
  - req_ready stays 0 for all requesters despite req_valid[0]=1.
  - Requester 0 is granted the cycle after the handshake with requester 1.
- Reset mid-WAIT: assert ARESET one cycle during WAIT.
  - All outputs 0 next cycle, state IDLE, pointer 0.
  - The adder's subsequent add_done produces no rsp_valid.
- Done/expiry collision: add_done on the exact expiry cycle → rsp_err=0, rsp_data=add_result.
